seq_pattern_gen: RTL and testbench

- Serial bit-pattern transmitter. Drives the one-bit-per-clock input stream consumed by the team's sequence-detector FSMs.
- Loads a parallel pattern and emits its bits MSB-first, one per clock.
- Optionally repeats the pattern with a programmable idle gap between repetitions.
- Used as the stimulus/traffic source on the serial link feeding the detectors, and as a self-test generator.

---
 rtl/seq_pkg.sv | 27 ++
 rtl/seq_pattern_gen_if.sv | 34 +++
 rtl/seq_down_cnt.sv | 35 +++
 rtl/seq_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_seq_pattern_gen.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg
// Shared definitions for the serial pattern generator: FSM state encoding,
// default pattern width and the length-normalisation helper.
package seq_pkg;

  // Default maximum pattern length in bits.
  localparam int SEQ_WIDTH = 8;

  // Binary-encoded FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  // A requested length of 0, or one longer than the pattern register,
  // means "send the whole register".
  function automatic int norm_len(input int len_v, input int width_v);
    if ((len_v == 0) || (len_v > width_v)) begin
      return width_v;
    end else begin
      return len_v;
    end
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if
// Request / serial-output bundle of the pattern generator.
//   master: drives start, pattern, len, rep, gap; observes ready, busy,
//           out, out_valid, done.
//   slave : the generator side.
interface seq_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int GAP_W = 4,
  parameter int REP_W = 3
) ();

  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] rep;
  logic [GAP_W-1:0] gap;
  logic             ready;
  logic             busy;
  logic             out;
  logic             out_valid;
  logic             done;

  modport master (
    output start, pattern, len, rep, gap,
    input  ready, busy, out, out_valid, done
  );

  modport slave (
    input  start, pattern, len, rep, gap,
    output ready, busy, out, out_valid, done
  );

endinterface

// File: rtl/seq_down_cnt.sv
// seq_down_cnt
// Loadable down-counter with zero flag. Decrement saturates at 0.
//   clk, CLR     : clock, synchronous active-high clear
//   load/load_val: parallel load (has priority over dec)
//   dec          : decrement by one when non-zero
//   zero         : count register equals 0
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         CLR,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count register: clear, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (CLR) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
// Serial bit-pattern transmitter: captures a pattern on start and sends
// bits len-1..0 one per clock, repeating rep extra times with gap idle
// cycles in between.
//   clk : system clock          CLR : synchronous active-high reset
//   bus : seq_pattern_gen_if.slave (start/pattern/len/rep/gap in,
//         ready/busy/out/out_valid/done out, all outputs registered)
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int LEN_W = 4,
  parameter int GAP_W = 4,
  parameter int REP_W = 3
) (
  input logic              clk,
  input logic              CLR,
  seq_pattern_gen_if.slave bus
);

  seq_state_t       state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;  // current bit sits in the MSB
  logic [WIDTH-1:0] pat_r;                 // captured pattern, left-aligned
  logic [LEN_W-1:0] lm1_r;                 // captured L-1
  logic [GAP_W-1:0] gap_r;
  logic             ready_r, busy_r, out_r, valid_r, done_r;

  int               l_int_s;
  logic [LEN_W-1:0] l_s;
  logic [WIDTH-1:0] aligned_s;
  logic             accept_s;

  logic             bit_load_s, bit_dec_s, bit_zero_s;
  logic             rep_load_s, rep_dec_s, rep_zero_s;
  logic             gap_load_s, gap_dec_s, gap_zero_s;
  logic [LEN_W-1:0] bit_ld_val_s;

  // Normalise the requested length and left-align the pattern so bit L-1
  // is the first to leave the MSB of the shift register.
  always_comb begin
    l_int_s   = norm_len(int'(bus.len), WIDTH);
    l_s       = LEN_W'(l_int_s);
    aligned_s = bus.pattern << (WIDTH - l_int_s);
    accept_s  = (state_r == S_IDLE) && bus.start;
    if (state_r == S_IDLE) begin
      bit_ld_val_s = l_s - LEN_W'(1);
    end else begin
      bit_ld_val_s = lm1_r;
    end
  end

  seq_down_cnt #(.W(LEN_W)) u_bit_cnt (
    .clk(clk), .CLR(CLR), .load(bit_load_s), .load_val(bit_ld_val_s),
    .dec(bit_dec_s), .zero(bit_zero_s)
  );

  seq_down_cnt #(.W(REP_W)) u_rep_cnt (
    .clk(clk), .CLR(CLR), .load(rep_load_s), .load_val(bus.rep),
    .dec(rep_dec_s), .zero(rep_zero_s)
  );

  // Loaded with gap-1 so the GAP state lasts exactly gap cycles.
  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .CLR(CLR), .load(gap_load_s), .load_val(gap_r - GAP_W'(1)),
    .dec(gap_dec_s), .zero(gap_zero_s)
  );

  // Next-state, shift-register and counter-control logic.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    bit_load_s  = 1'b0;
    bit_dec_s   = 1'b0;
    rep_load_s  = 1'b0;
    rep_dec_s   = 1'b0;
    gap_load_s  = 1'b0;
    gap_dec_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt_s = S_SEND;
          shreg_nxt_s = aligned_s;
          bit_load_s  = 1'b1;
          rep_load_s  = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SEND: begin
        if (!bit_zero_s) begin
          shreg_nxt_s = {shreg_r[WIDTH-2:0], 1'b0};
          bit_dec_s   = 1'b1;
        end else if (rep_zero_s) begin
          state_nxt_s = S_DONE;
        end else begin
          // Reload for the next repetition; back-to-back when gap is 0.
          rep_dec_s   = 1'b1;
          shreg_nxt_s = pat_r;
          bit_load_s  = 1'b1;
          if (gap_r != '0) begin
            state_nxt_s = S_GAP;
            gap_load_s  = 1'b1;
          end else begin
            state_nxt_s = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (gap_zero_s) begin
          state_nxt_s = S_SEND;
        end else begin
          gap_dec_s = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs (outputs follow the next state
  // so they line up with the state they describe).
  always_ff @(posedge clk) begin
    if (CLR) begin
      state_r <= S_IDLE;
      shreg_r <= '0;
      pat_r   <= '0;
      lm1_r   <= '0;
      gap_r   <= '0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      out_r   <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      shreg_r <= shreg_nxt_s;
      if (accept_s) begin
        pat_r <= aligned_s;
        lm1_r <= l_s - LEN_W'(1);
        gap_r <= bus.gap;
      end else begin
        pat_r <= pat_r;
        lm1_r <= lm1_r;
        gap_r <= gap_r;
      end
      ready_r <= (state_nxt_s == S_IDLE);
      busy_r  <= (state_nxt_s == S_SEND) || (state_nxt_s == S_GAP);
      valid_r <= (state_nxt_s == S_SEND);
      out_r   <= (state_nxt_s == S_SEND) && shreg_nxt_s[WIDTH-1];
      done_r  <= (state_nxt_s == S_DONE);
    end
  end

  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.out       = out_r;
  assign bus.out_valid = valid_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen
// Directed bench for seq_pattern_gen. Stimulus pushes hand-computed
// expected bits (with their cycle) and done cycles into queues; a monitor
// on the falling edge pops and compares whenever the DUT presents them.
module tb_seq_pattern_gen;

  typedef struct {
    int   cyc;
    logic b;
  } exp_t;

  logic clk = 1'b0;
  logic CLR = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   errs = 0;
  bit   mon_en = 1'b0;
  bit   prev_done = 1'b0;
  exp_t exp_q[$];
  int   done_q[$];

  seq_pattern_gen_if #(.WIDTH(8), .LEN_W(4), .GAP_W(4), .REP_W(3)) bus ();

  seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .GAP_W(4), .REP_W(3)) dut (
    .clk(clk),
    .CLR(CLR),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Queue expected traffic relative to base; cycle m (1-based) of the
  // transfer is sampled with cyc == base+m-1. done_m==0 means no done.
  task automatic push_seq(input logic [7:0] bits, input int nb, input int reps,
                          input int g, input int done_m);
    int m;
    logic [7:0] bv;
    bv = bits;
    m = 1;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < nb; i++) begin
        exp_q.push_back('{cyc: base + m - 1, b: bv[nb-1-i]});
        m++;
      end
      if (r < reps - 1) m += g;
    end
    if (done_m != 0) done_q.push_back(base + done_m - 1);
  endtask

  task automatic start_xfer(input logic [7:0] p, input logic [3:0] l,
                            input logic [2:0] r, input logic [3:0] g);
    @(negedge clk);
    bus.pattern = p;
    bus.len     = l;
    bus.rep     = r;
    bus.gap     = g;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    base      = cyc;
    bus.start = 1'b0;
  endtask

  task automatic drain(input string name, input int maxc);
    for (int i = 0; i < maxc && (exp_q.size() != 0 || done_q.size() != 0); i++)
      @(negedge clk);
    #1;
    chk({name, "_drained"}, exp_q.size() + done_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: compares every presented bit and done pulse with the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_done) chk("ready_after_done", {bus.ready, bus.done}, 2'b10);
      prev_done = bus.done;
      if (bus.out_valid) begin
        chk("busy_in_send", {bus.busy, bus.ready}, 2'b10);
        chk("bit_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bit_cycle", cyc, e.cyc);
          chk("bit_value", bus.out, e.b);
        end
      end else begin
        chk("out_zero_invalid", bus.out, 0);
      end
      if (bus.done) begin
        chk("done_flags", {bus.ready, bus.busy, bus.out_valid}, 3'b000);
        chk("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    bus.start = 1'b0; bus.pattern = 8'h00; bus.len = 4'd0;
    bus.rep = 3'd0; bus.gap = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    CLR = 1'b0;
    chk("reset_state", {bus.out, bus.out_valid, bus.busy, bus.ready, bus.done}, 5'b00010);
    mon_en = 1'b1;

    // Basic send: 8'hB4 MSB first, done cycle 9, ready cycle 10.
    start_xfer(8'hB4, 4'd8, 3'd0, 4'd0);
    push_seq(8'b10110100, 8, 1, 0, 9);
    drain("basic", 40);

    // Short pattern, len=4.
    start_xfer(8'h0D, 4'd4, 3'd0, 4'd0);
    push_seq(8'b00001101, 4, 1, 0, 5);
    drain("short", 40);

    // len=0 sends all 8 bits.
    start_xfer(8'h0D, 4'd0, 3'd0, 4'd0);
    push_seq(8'b00001101, 8, 1, 0, 9);
    drain("len0", 40);

    // len > WIDTH also sends all 8 bits.
    start_xfer(8'hA5, 4'd12, 3'd0, 4'd0);
    push_seq(8'b10100101, 8, 1, 0, 9);
    drain("len_over", 40);

    // Repeat with gap=2: done cycle 11.
    start_xfer(8'h0D, 4'd4, 3'd1, 4'd2);
    push_seq(8'b00001101, 4, 2, 2, 11);
    drain("rep_gap", 40);

    // Repeat back-to-back: done cycle 9.
    start_xfer(8'h0D, 4'd4, 3'd1, 4'd0);
    push_seq(8'b00001101, 4, 2, 0, 9);
    drain("rep_nogap", 40);

    // Ignored inputs: start and field changes in SEND, GAP and DONE.
    start_xfer(8'h0D, 4'd4, 3'd1, 4'd2);
    push_seq(8'b00001101, 4, 2, 2, 11);
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      bus.start   = 1'b1;
      bus.pattern = 8'hF0 ^ 8'(i);
      bus.len     = 4'(i);
      bus.rep     = 3'd7;
      bus.gap     = 4'd1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    drain("ignored", 40);

    // Reset at the third bit of an 8-bit send: no done, back to IDLE.
    start_xfer(8'hB4, 4'd8, 3'd0, 4'd0);
    push_seq(8'b00000101, 3, 1, 0, 0);
    repeat (3) @(negedge clk);
    CLR = 1'b1;
    @(posedge clk);
    #1;
    CLR = 1'b0;
    chk("mid_reset_state", {bus.out, bus.out_valid, bus.busy, bus.ready, bus.done}, 5'b00010);
    repeat (12) @(negedge clk);
    #1;
    chk("mid_reset_quiet", exp_q.size() + done_q.size(), 0);

    // CLR together with start stays in IDLE.
    @(negedge clk);
    CLR = 1'b1;
    bus.start = 1'b1;
    bus.pattern = 8'hFF; bus.len = 4'd8; bus.rep = 3'd0; bus.gap = 4'd0;
    @(posedge clk);
    #1;
    CLR = 1'b0;
    bus.start = 1'b0;
    chk("clr_start_state", {bus.out, bus.out_valid, bus.busy, bus.ready, bus.done}, 5'b00010);
    repeat (10) @(negedge clk);
    #1;
    chk("clr_start_ready", bus.ready, 1);

    // Boundary: L=1, rep=7, gap=15 -> eight pulses, done at cycle 114.
    start_xfer(8'h01, 4'd1, 3'd7, 4'd15);
    push_seq(8'b00000001, 1, 8, 15, 114);
    drain("boundary", 300);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
